// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller between instruction fetch, the
// load/store buffer and a single-port 8-bit RAM/IO bus. One request at a time
// is split into byte cycles; read bytes are assembled little-endian.
// Optional feature: define MEM_CTRL_RR_ARB_EN for round-robin arbitration on
// a fetch/LSB tie; when undefined the LSB always wins a tie.
module mem_ctrl #(
    parameter logic [31:0] IO_MASK = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_valid,
    input  logic        lsb_is_store,
    input  logic [31:0] lsb_addr,
    input  logic [2:0]  lsb_len,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [2:0] {IDLE, IFETCH, LOAD, STORE, DONE} state_t;

    state_t      state_q, state_d;
    logic        last_lsb_q, last_lsb_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_io_q, is_io_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic        lsb_done_q, lsb_done_d;
    logic [31:0] lsb_rdata_q, lsb_rdata_d;

    logic        take_if, take_lsb, if_ok, lsb_io;
    logic [2:0]  cnt_inc;
    logic [31:0] asm_fill;

    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign lsb_done  = lsb_done_q;
    assign lsb_rdata = lsb_rdata_q;
    assign mem_dout  = mem_dout_q;
    assign mem_a     = mem_a_q;
    assign mem_wr    = mem_wr_q & rdy;

    assign lsb_io  = (lsb_addr & IO_MASK) == IO_MASK;
    assign cnt_inc = cnt_q + 3'd1;

    // Merge the byte returned this cycle (for the address issued last cycle) into the assembly word
    always_comb begin
        asm_fill = asm_q;
        case (cnt_q)
            3'd1:    asm_fill[7:0]   = mem_din;
            3'd2:    asm_fill[15:8]  = mem_din;
            3'd3:    asm_fill[23:16] = mem_din;
            3'd4:    asm_fill[31:24] = mem_din;
            default: asm_fill = asm_q;
        endcase
    end

    // Pick which requester an IDLE edge would accept; rollback masks a pending fetch
    always_comb begin
        take_if  = 1'b0;
        take_lsb = 1'b0;
        if_ok    = if_valid && !rollback;
        if (if_ok && lsb_valid) begin
`ifdef MEM_CTRL_RR_ARB_EN
            if (last_lsb_q) take_if  = 1'b1;
            else            take_lsb = 1'b1;
`else
            take_lsb = 1'b1;
`endif
        end else if (if_ok) begin
            take_if = 1'b1;
        end else if (lsb_valid) begin
            take_lsb = 1'b1;
        end
    end

    // Next-state and output-register logic; everything holds while rdy is low
    always_comb begin
        state_d     = state_q;
        last_lsb_d  = last_lsb_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;
        is_io_d     = is_io_q;
        asm_d       = asm_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        if_done_d   = if_done_q;
        if_data_d   = if_data_q;
        lsb_done_d  = lsb_done_q;
        lsb_rdata_d = lsb_rdata_q;
        if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (take_lsb) begin
                        last_lsb_d = 1'b1;
                        addr_d     = lsb_addr;
                        len_d      = lsb_len;
                        wdata_d    = lsb_wdata;
                        is_io_d    = lsb_io;
                        cnt_d      = 3'd0;
                        asm_d      = 32'd0;
                        mem_a_d    = lsb_addr;
                        mem_dout_d = lsb_wdata[7:0];
                        if (lsb_is_store) begin
                            state_d  = STORE;
                            mem_wr_d = !(lsb_io && io_buffer_full);
                        end else begin
                            state_d = LOAD;
                        end
                    end else if (take_if) begin
                        last_lsb_d = 1'b0;
                        addr_d     = if_addr;
                        len_d      = 3'd4;
                        cnt_d      = 3'd0;
                        asm_d      = 32'd0;
                        mem_a_d    = if_addr;
                        state_d    = IFETCH;
                    end
                end
                IFETCH, LOAD: begin
                    if ((state_q == IFETCH && rollback) || (state_q == LOAD && !lsb_valid)) begin
                        state_d = IDLE;
                    end else begin
                        asm_d = asm_fill;
                        cnt_d = cnt_inc;
                        if (cnt_inc < len_q) begin
                            mem_a_d = addr_q + {29'd0, cnt_inc};
                        end
                        if (cnt_q == len_q) begin
                            state_d = DONE;
                            cnt_d   = cnt_q;
                            if (state_q == IFETCH) begin
                                if_done_d = 1'b1;
                                if_data_d = asm_fill;
                            end else begin
                                lsb_done_d  = 1'b1;
                                lsb_rdata_d = asm_fill;
                            end
                        end
                    end
                end
                STORE: begin
                    if (mem_wr_q) begin
                        if (cnt_inc >= len_q) begin
                            state_d    = DONE;
                            mem_wr_d   = 1'b0;
                            lsb_done_d = 1'b1;
                        end else begin
                            cnt_d      = cnt_inc;
                            mem_a_d    = addr_q + {29'd0, cnt_inc};
                            mem_dout_d = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
                            mem_wr_d   = !(is_io_q && io_buffer_full);
                        end
                    end else begin
                        mem_wr_d = !(is_io_q && io_buffer_full);
                    end
                end
                DONE: begin
                    if_done_d  = 1'b0;
                    lsb_done_d = 1'b0;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_lsb_q  <= 1'b0;
            addr_q      <= 32'd0;
            len_q       <= 3'd0;
            cnt_q       <= 3'd0;
            wdata_q     <= 32'd0;
            is_io_q     <= 1'b0;
            asm_q       <= 32'd0;
            mem_a_q     <= 32'd0;
            mem_dout_q  <= 8'd0;
            mem_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            if_data_q   <= 32'd0;
            lsb_done_q  <= 1'b0;
            lsb_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            last_lsb_q  <= last_lsb_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            wdata_q     <= wdata_d;
            is_io_q     <= is_io_d;
            asm_q       <= asm_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            if_done_q   <= if_done_d;
            if_data_q   <= if_data_d;
            lsb_done_q  <= lsb_done_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a small RAM model.
// Compile with MEM_CTRL_RR_ARB_EN to check the round-robin tie behaviour.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_valid, lsb_is_store;
    logic [31:0] lsb_addr;
    logic [2:0]  lsb_len;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_valid(lsb_valid), .lsb_is_store(lsb_is_store), .lsb_addr(lsb_addr),
        .lsb_len(lsb_len), .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // RAM contents used by the directed tests
    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h100: ram_byte = 8'h13;
            32'h101: ram_byte = 8'h00;
            32'h102: ram_byte = 8'h00;
            32'h103: ram_byte = 8'h93;
            32'h204: ram_byte = 8'h80;
            32'h205: ram_byte = 8'hFF;
            default: ram_byte = a[7:0] ^ 8'h3C;
        endcase
    endfunction

    // RAM returns the byte for the previous cycle's address; it freezes with rdy like the rest of the system
    always @(posedge clk or posedge rst) begin
        if (rst)      mem_din <= 8'h00;
        else if (rdy) mem_din <= ram_byte(mem_a);
    end

    typedef struct {
        logic        if_v;
        logic        lsb_v;
        logic        st;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [31:0] wd;
        logic        chk_a;
        logic [31:0] e_a;
        logic        e_wr;
        logic [7:0]  e_dout;
        logic        e_ifd;
        logic        e_lsd;
        logic        chk_d;
        logic [31:0] e_d;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic if_v, input logic lsb_v, input logic st,
                                input logic [31:0] addr, input logic [2:0] len, input logic [31:0] wd,
                                input logic chk_a, input logic [31:0] e_a, input logic e_wr,
                                input logic [7:0] e_dout, input logic e_ifd, input logic e_lsd,
                                input logic chk_d, input logic [31:0] e_d);
        vec_t v;
        v.if_v = if_v; v.lsb_v = lsb_v; v.st = st; v.addr = addr; v.len = len; v.wd = wd;
        v.chk_a = chk_a; v.e_a = e_a; v.e_wr = e_wr; v.e_dout = e_dout;
        v.e_ifd = e_ifd; v.e_lsd = e_lsd; v.chk_d = chk_d; v.e_d = e_d;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic applyStimulus(input vec_t v);
        if_valid       = v.if_v;
        if_addr        = v.addr;
        lsb_valid      = v.lsb_v;
        lsb_is_store   = v.st;
        lsb_addr       = v.addr;
        lsb_len        = v.len;
        lsb_wdata      = v.wd;
        rollback       = 1'b0;
        io_buffer_full = 1'b0;
        rdy            = 1'b1;
    endtask

    task automatic check_vector(input int i, input vec_t v);
        checkOutput($sformatf("v%0d if_done", i), {31'd0, if_done}, {31'd0, v.e_ifd});
        checkOutput($sformatf("v%0d lsb_done", i), {31'd0, lsb_done}, {31'd0, v.e_lsd});
        checkOutput($sformatf("v%0d mem_wr", i), {31'd0, mem_wr}, {31'd0, v.e_wr});
        if (v.chk_a) checkOutput($sformatf("v%0d mem_a", i), mem_a, v.e_a);
        if (v.e_wr)  checkOutput($sformatf("v%0d mem_dout", i), {24'd0, mem_dout}, {24'd0, v.e_dout});
        if (v.chk_d && v.e_ifd) checkOutput($sformatf("v%0d if_data", i), if_data, v.e_d);
        if (v.chk_d && v.e_lsd) checkOutput($sformatf("v%0d lsb_rdata", i), lsb_rdata, v.e_d);
    endtask

    // Tick until a done pulse appears or the budget runs out
    task automatic wait_done(input int max_cycles, output int cycles, output logic got_if, output logic got_lsb);
        cycles  = 0;
        got_if  = 1'b0;
        got_lsb = 1'b0;
        while (cycles < max_cycles) begin
            tick();
            cycles++;
            if (if_done || lsb_done) begin
                got_if  = if_done;
                got_lsb = lsb_done;
                break;
            end
        end
    endtask

    // Both requesters rise together; checks who wins and the done latency
    task automatic race(input logic expect_lsb, input string tag);
        int   c;
        logic gi, gl;
        if_valid = 1'b1; if_addr = 32'h100;
        lsb_valid = 1'b1; lsb_is_store = 1'b0; lsb_addr = 32'h204; lsb_len = 3'd1;
        wait_done(20, c, gi, gl);
        checkOutput({tag, " lsb served"}, {31'd0, gl}, {31'd0, expect_lsb});
        checkOutput({tag, " fetch served"}, {31'd0, gi}, {31'd0, !expect_lsb});
        checkOutput({tag, " latency"}, c, expect_lsb ? 32'd3 : 32'd6);
        if (gi) checkOutput({tag, " if_data"}, if_data, 32'h9300_0013);
        if (gl) checkOutput({tag, " lsb_rdata"}, lsb_rdata, 32'h0000_0080);
        if_valid = 1'b0; lsb_valid = 1'b0;
        tick();
    endtask

    initial begin
        int   c;
        logic gi, gl;

        // Fetch at 0x100, then LSB load with valid held through DONE, then a 4-byte store
        vecs.push_back(mk(1,0,0,32'h100,3'd4,0, 1,32'h100,0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,32'h100,3'd4,0, 1,32'h101,0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,32'h100,3'd4,0, 1,32'h102,0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,32'h100,3'd4,0, 1,32'h103,0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,32'h100,3'd4,0, 0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,32'h100,3'd4,0, 0,0,0,0, 1,0,1,32'h9300_0013));
        vecs.push_back(mk(0,0,0,32'h100,3'd4,0, 0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(0,1,0,32'h204,3'd2,0, 1,32'h204,0,0, 0,0,0,0));
        vecs.push_back(mk(0,1,0,32'h204,3'd2,0, 1,32'h205,0,0, 0,0,0,0));
        vecs.push_back(mk(0,1,0,32'h204,3'd2,0, 0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(0,1,0,32'h204,3'd2,0, 0,0,0,0, 0,1,1,32'h0000_FF80));
        vecs.push_back(mk(0,1,0,32'h204,3'd2,0, 1,32'h205,0,0, 0,0,0,0));
        vecs.push_back(mk(0,0,0,32'h204,3'd2,0, 1,32'h205,0,0, 0,0,0,0));
        vecs.push_back(mk(0,1,1,32'h1000,3'd4,32'hDEADBEEF, 1,32'h1000,1,8'hEF, 0,0,0,0));
        vecs.push_back(mk(0,1,1,32'h1000,3'd4,32'hDEADBEEF, 1,32'h1001,1,8'hBE, 0,0,0,0));
        vecs.push_back(mk(0,1,1,32'h1000,3'd4,32'hDEADBEEF, 1,32'h1002,1,8'hAD, 0,0,0,0));
        vecs.push_back(mk(0,1,1,32'h1000,3'd4,32'hDEADBEEF, 1,32'h1003,1,8'hDE, 0,0,0,0));
        vecs.push_back(mk(0,1,1,32'h1000,3'd4,32'hDEADBEEF, 0,0,0,0, 0,1,0,0));
        vecs.push_back(mk(0,0,1,32'h1000,3'd4,32'hDEADBEEF, 0,0,0,0, 0,0,0,0));

        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        if_valid = 1'b0; if_addr = 32'd0; lsb_valid = 1'b0; lsb_is_store = 1'b0;
        lsb_addr = 32'd0; lsb_len = 3'd0; lsb_wdata = 32'd0;
        tick();
        tick();
        checkOutput("reset mem_a", mem_a, 32'd0);
        checkOutput("reset mem_dout", {24'd0, mem_dout}, 32'd0);
        checkOutput("reset mem_wr", {31'd0, mem_wr}, 32'd0);
        checkOutput("reset if_done", {31'd0, if_done}, 32'd0);
        checkOutput("reset if_data", if_data, 32'd0);
        checkOutput("reset lsb_done", {31'd0, lsb_done}, 32'd0);
        checkOutput("reset lsb_rdata", lsb_rdata, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            tick();
            check_vector(i, vecs[i]);
        end

        // IO store stalled by a full buffer sampled at edges 0..2
        lsb_valid = 1'b1; lsb_is_store = 1'b1; lsb_addr = 32'h0003_0000; lsb_len = 3'd1;
        lsb_wdata = 32'h0000_00A5; io_buffer_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("io stall c%0d mem_wr", k), {31'd0, mem_wr}, 32'd0);
            checkOutput($sformatf("io stall c%0d lsb_done", k), {31'd0, lsb_done}, 32'd0);
        end
        io_buffer_full = 1'b0;
        tick();
        checkOutput("io c3 mem_wr", {31'd0, mem_wr}, 32'd1);
        checkOutput("io c3 mem_a", mem_a, 32'h0003_0000);
        checkOutput("io c3 mem_dout", {24'd0, mem_dout}, 32'h0000_00A5);
        checkOutput("io c3 lsb_done", {31'd0, lsb_done}, 32'd0);
        tick();
        checkOutput("io c4 lsb_done", {31'd0, lsb_done}, 32'd1);
        checkOutput("io c4 mem_wr", {31'd0, mem_wr}, 32'd0);
        lsb_valid = 1'b0;
        tick();

        // Rollback in cycle 2 of a fetch, then a load issued right away
        if_valid = 1'b1; if_addr = 32'h100;
        tick(); tick(); tick();
        rollback = 1'b1;
        tick();
        checkOutput("rollback c3 mem_a", mem_a, 32'h102);
        checkOutput("rollback c3 if_done", {31'd0, if_done}, 32'd0);
        rollback = 1'b0; if_valid = 1'b0;
        lsb_valid = 1'b1; lsb_is_store = 1'b0; lsb_addr = 32'h204; lsb_len = 3'd1;
        tick();
        checkOutput("after rollback load accepted", mem_a, 32'h204);
        wait_done(10, c, gi, gl);
        checkOutput("after rollback lsb_done", {31'd0, gl}, 32'd1);
        checkOutput("after rollback no if_done", {31'd0, gi}, 32'd0);
        checkOutput("after rollback latency", c, 32'd2);
        checkOutput("after rollback lsb_rdata", lsb_rdata, 32'h0000_0080);
        lsb_valid = 1'b0;
        tick();

        // Rollback held high during a load does not disturb it
        lsb_valid = 1'b1; lsb_is_store = 1'b0; lsb_addr = 32'h204; lsb_len = 3'd2;
        rollback = 1'b1;
        tick();
        wait_done(10, c, gi, gl);
        checkOutput("load rollback lsb_done", {31'd0, gl}, 32'd1);
        checkOutput("load rollback latency", c, 32'd3);
        checkOutput("load rollback lsb_rdata", lsb_rdata, 32'h0000_FF80);
        lsb_valid = 1'b0; rollback = 1'b0;
        tick();

        // rdy low during a store freezes state and masks mem_wr
        lsb_valid = 1'b1; lsb_is_store = 1'b1; lsb_addr = 32'h2000; lsb_len = 3'd2;
        lsb_wdata = 32'h0000_1234;
        tick();
        checkOutput("freeze c0 mem_wr", {31'd0, mem_wr}, 32'd1);
        rdy = 1'b0;
        #1;
        checkOutput("freeze mem_wr masked", {31'd0, mem_wr}, 32'd0);
        tick(); tick();
        checkOutput("freeze mem_a held", mem_a, 32'h2000);
        checkOutput("freeze mem_dout held", {24'd0, mem_dout}, 32'h0000_0034);
        checkOutput("freeze mem_wr low", {31'd0, mem_wr}, 32'd0);
        rdy = 1'b1;
        #1;
        checkOutput("unfreeze mem_wr", {31'd0, mem_wr}, 32'd1);
        tick();
        checkOutput("unfreeze c1 mem_a", mem_a, 32'h2001);
        checkOutput("unfreeze c1 mem_dout", {24'd0, mem_dout}, 32'h0000_0012);
        tick();
        checkOutput("unfreeze c2 lsb_done", {31'd0, lsb_done}, 32'd1);
        lsb_valid = 1'b0;
        tick();

        // Reset in the middle of a store produces no done
        lsb_valid = 1'b1; lsb_is_store = 1'b1; lsb_addr = 32'h1000; lsb_len = 3'd4;
        lsb_wdata = 32'hDEADBEEF;
        tick(); tick();
        rst = 1'b1;
        #1;
        checkOutput("mid reset mem_wr", {31'd0, mem_wr}, 32'd0);
        checkOutput("mid reset mem_a", mem_a, 32'd0);
        lsb_valid = 1'b0;
        tick();
        rst = 1'b0;
        wait_done(6, c, gi, gl);
        checkOutput("mid reset no done", {30'd0, gi, gl}, 32'd0);

        // Arbitration ties starting from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        race(1'b1, "tie1");
`ifdef MEM_CTRL_RR_ARB_EN
        race(1'b0, "tie2");
`else
        race(1'b1, "tie2");
`endif

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the core's two memory clients, instruction fetch and the load/store buffer, and the single-port 8-bit RAM/IO bus. It accepts one word-sized or smaller request at a time and runs it as a sequence of byte cycles. Read bytes are assembled little-endian, and the whole word is returned with a one-cycle done pulse. Stores stall while the IO output buffer is full.

## Interface
Parameters:
- IO_MASK, default 32'h0003_0000: address bits that select IO space.
  - An access is IO when (addr & IO_MASK) == IO_MASK.

Ports:
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- rdy, in, 1: global enable.
  - Low: all state frozen, and mem_wr is forced to 0.
- rollback, in, 1: misprediction flush. Aborts an instruction fetch only.
- if_valid, in, 1: fetch request. Held high until if_done.
- if_addr, in, 32: fetch address. Always 4 bytes.
- if_done, out, 1: one-cycle pulse. if_data is valid in the same cycle.
- if_data, out, 32: fetched word.
- lsb_valid, in, 1: LSB request. Held high until lsb_done.
- lsb_is_store, in, 1: 1 = store, 0 = load.
- lsb_addr, in, 32: byte address.
- lsb_len, in, 3: byte count. Legal values are 1, 2 and 4.
- lsb_wdata, in, 32: store data. Low lsb_len bytes are used.
- lsb_done, out, 1: one-cycle pulse. Load data is valid in the same cycle.
- lsb_rdata, out, 32: raw load bytes, zero-extended. Sign extension is done by the LSB.
- mem_din, in, 8: RAM read byte.
- mem_dout, out, 8: RAM write byte.
- mem_a, out, 32: RAM byte address.
- mem_wr, out, 1: write strobe.
- io_buffer_full, in, 1: IO sink cannot accept a byte.

## Operation
- States:
  - IDLE
  - IFETCH
  - LOAD
  - STORE
  - DONE: cool-down, exactly one cycle.
- Reset values:
  - state = IDLE; last_served = IFETCH.
  - All outputs 0: mem_a, mem_dout, mem_wr, if_done, if_data, lsb_done, lsb_rdata.
- IDLE arbitration at each edge with rdy = 1:
  - Only one requester valid: serve it.
  - Both valid: arbitration rule set by the macro (see Configuration).
- The captured address and length are latched at acceptance.
  - Request inputs are ignored afterwards, except lsb_valid as an abort.
- LOAD and IFETCH read timing:
  - mem_din in cycle t is the byte addressed by mem_a in cycle t-1.
  - Byte k (k = 0..len-1) is placed at bits [8k+7:8k].
  - Unread upper bytes of lsb_rdata are 0.
- STORE: mem_wr = 1, mem_a = addr + k, mem_dout = wdata[8k+7:8k].
- IO store stall:
  - Applies when an edge samples io_buffer_full = 1 and the target is IO.
  - The next cycle drives mem_wr = 0 and k does not advance.
- On completion:
  - The done pulse and the data register are set together.
  - state goes to DONE.
  - DONE ignores all requests, so a requester's still-high valid is not re-accepted.
  - DONE returns to IDLE.
- rollback = 1 while in IFETCH: go to IDLE, with no if_done and no DONE cycle.
- rollback = 1 while in IDLE: a pending if_valid is not accepted in that edge.
- rollback never affects LOAD or STORE.
- lsb_valid = 0 while in LOAD (LSB was flushed): go to IDLE with no lsb_done.
- A STORE always completes.
- rst asserted mid-transaction: immediate return to reset values. No partial done is produced.
- Address arithmetic is 32-bit modulo.

## Timing
- Edge 0 is the acceptance edge; cycle k is the cycle after edge k.
- Load or fetch of len bytes:
  - mem_a = addr + k in cycles 0..len-1.
  - Done is high in cycle len+1.
  - DONE state is in cycle len+1; IDLE is in cycle len+2.
  - 4-byte fetch: if_done in cycle 5.
- Store of len bytes with no stall:
  - mem_wr is high in cycles 0..len-1.
  - lsb_done is high in cycle len (mem_wr = 0 in that cycle).
  - Each stall cycle adds 1.
- Back-to-back throughput: one new acceptance at the earliest 2 cycles after the done pulse begins.
- rdy = 0 inserts frozen cycles. No output register changes during them.

## Configuration
- MEM_CTRL_RR_ARB_EN defined: round-robin.
  - On a tie, serve the requester not equal to last_served.
  - last_served updates at every acceptance.
- Undefined: fixed priority. LSB always wins a tie.
  - last_served is still maintained but unused.

## Test plan
- Reset, then fetch at 0x100 with RAM bytes 13 00 00 93 -> if_data = 0x9300_0013, if_done in cycle 5 only, mem_a steps 0x100..0x103.
- LSB load of len 2 at 0x204 with bytes 80 FF -> lsb_rdata = 0x0000_FF80, lsb_done in cycle 3; lsb_valid held high through DONE is not re-accepted.
- Store of len 4 of 0xDEADBEEF to 0x1000 -> mem_wr in cycles 0..3 with mem_dout EF BE AD DE, lsb_done in cycle 4.
- Store of len 1 to 0x30000 with io_buffer_full high for 3 cycles from edge 0 -> mem_wr delayed 3 cycles, lsb_done in cycle 4.
- if_valid and lsb_valid rise together twice, with the macro defined -> LSB served first, then fetch; without the macro -> LSB served both times.
- rollback in cycle 2 of a fetch -> no if_done, IDLE next cycle. rollback during a load -> load completes with lsb_done.
